uart_tx_arb: RTL
================

# uart_tx_arb

Round-robin arbiter that shares the single UART transmit interface (`tx_req`/`tx_din`/`tx_ready`) among `NUM_SRC` byte-stream requesters. Each grant sends an optional one-byte header identifying the source, followed by a burst of that source's bytes. The burst ends on the source's last byte, at `MAX_BURST` bytes, or after an idle timeout. The block sits between on-chip producers (debug, status, loopback) and the `uart` transmit port; it drives `tx_req` directly as the uart write strobe.

## Interface
- `NUM_SRC`, 4: number of requesters, 1..16.
- `WIDTH`, 8: byte width; matches uart `WIDTH`.
- `MAX_BURST`, 16: maximum data bytes per grant, ≥1.
- `ADD_HEADER`, 1: 1 = send header byte before each burst.
- `HDR_BASE`, 8'hF0: header byte = `HDR_BASE | grant_id`; low 4 bits of `HDR_BASE` must be 0.
- `IDLE_TIMEOUT`, 255: cycles the granted source may hold `src_valid` low mid-burst before the burst ends; 0 disables the timeout.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `src_valid` in NUM_SRC: per-source byte available.
- `src_data` in NUM_SRC*WIDTH: source i occupies bits [i*WIDTH +: WIDTH].
- `src_last` in NUM_SRC: byte is the last of the source's packet.
- `src_ready` out NUM_SRC: byte accepted this cycle.
- `tx_req` out 1: uart write strobe; never high unless `tx_ready`=1.
- `tx_din` out WIDTH: uart write data.
- `tx_ready` in 1: uart TX FIFO can accept a byte.
- `grant_id` out ID_W: current/last granted source, where ID_W = max(1, clog2(NUM_SRC)).
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, HEADER, DATA. State, `grant_id`, `last_id`, `burst_cnt` and `idle_cnt` are registered. `tx_req`, `tx_din` and `src_ready` are combinational from state plus inputs.
- **IDLE**
  - If any `src_valid` is set, pick the first set bit scanning from `last_id+1` upward with wrap-around (mod NUM_SRC).
  - Load `grant_id`, clear `burst_cnt` and `idle_cnt`.
  - Next state is HEADER if `ADD_HEADER`, else DATA.
  - `tx_req`=0 and all `src_ready`=0.
- **HEADER**
  - `tx_din`=`HDR_BASE | grant_id`, `tx_req`=`tx_ready`.
  - On `tx_req`, go to DATA.
  - The header is sent even if `src_valid[g]` has dropped.
- **DATA**
  - With g = `grant_id`: `src_ready[g]`=`tx_ready`, `tx_req`=`tx_ready & src_valid[g]`, `tx_din`=`src_data[g]`. Other `src_ready` bits are 0.
  - On a transfer: `burst_cnt`++, `idle_cnt` cleared.
  - Exit to IDLE when the transfer has `src_last[g]`=1, or when `burst_cnt`+1 = `MAX_BURST`. If both hold in the same cycle, exit once.
  - Cycles with `src_valid[g]`=0 increment `idle_cnt`. Cycles with `src_valid[g]`=1 and `tx_ready`=0 are backpressure: they do not count toward the timeout and clear `idle_cnt`.
  - If `IDLE_TIMEOUT`≠0 and `idle_cnt` reaches `IDLE_TIMEOUT`, exit to IDLE with no byte sent.
  - On any exit, `last_id` ← g.
- A source cut off by `MAX_BURST` re-arbitrates normally; its remaining bytes follow under a fresh header.
- Counter widths:
  - `burst_cnt`: clog2(MAX_BURST+1) bits.
  - `idle_cnt`: clog2(IDLE_TIMEOUT+1) bits, saturating.
- With `NUM_SRC`=1, `grant_id` is constant 0.

## Timing
- Reset (async assert, sync deassert by system):
  - State IDLE.
  - `grant_id`=0; `last_id`=NUM_SRC-1, so the first grant goes to source 0 on a tie.
  - `busy`=0, `tx_req`=0, `src_ready`=0, `tx_din`=0.
- Reset mid-burst: the FSM returns to IDLE immediately and the partial packet is abandoned. Sources must tolerate this.
- Latency:
  - `src_valid` rise in IDLE → HEADER next cycle.
  - Header strobe in the first HEADER cycle with `tx_ready`=1.
  - First data byte in the following cycle at the earliest.
- Throughput: one byte per cycle while `tx_ready` and `src_valid[g]` stay high.
- Arbitration overhead: 1 IDLE cycle between bursts (+1 header cycle if enabled).
- Requests arriving during a burst are not considered until the next IDLE cycle.

## Test plan
- **Single source:** source 2 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33), `tx_ready`=1. Required tx strobes: 0xF2, 0x11, 0x22, 0x33 on consecutive cycles; `busy` falls the cycle after 0x33.
- **Fairness:** all 4 sources continuously valid with 1-byte packets. Required grant order 0, 1, 2, 3, 0, with headers 0xF0, 0xF1, 0xF2, 0xF3, 0xF0.
- **Burst cap:** `MAX_BURST`=4, source 1 streams 6 bytes with last on byte 6. Required: 0xF1 + 4 bytes, IDLE, 0xF1 + 2 bytes; no byte lost or duplicated.
- **Backpressure:** during DATA, hold `tx_ready`=0 for 10 cycles. Required: `tx_req`=0 and `src_ready`=0 throughout; byte order preserved; no timeout fired.
- **Timeout:** `IDLE_TIMEOUT`=8, source 0 sends 1 non-last byte then drops valid. Required: return to IDLE 8 cycles later, then source 1's pending request is granted.
- **Reset mid-burst:** assert `rst` while in DATA. Required: same cycle `tx_req`=0 and `busy`=0; after release the first grant goes to source 0.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that multiplexes NUM_SRC byte streams onto one UART TX
// write port, optionally prefixing each burst with a source-ID header byte.
module uart_tx_arb #(
    parameter int unsigned      NUM_SRC      = 4,
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      MAX_BURST    = 16,
    parameter int unsigned      ADD_HEADER   = 1,
    parameter logic [WIDTH-1:0] HDR_BASE     = WIDTH'(8'hF0),
    parameter int unsigned      IDLE_TIMEOUT = 255,
    localparam int unsigned     ID_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_last,
    output logic [NUM_SRC-1:0]       src_ready,
    output logic                     tx_req,
    output logic [WIDTH-1:0]         tx_din,
    input  logic                     tx_ready,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    localparam int unsigned BC_W = $clog2(MAX_BURST + 1);
    localparam int unsigned IC_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [IC_W-1:0] IC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   grant_nxt;
    logic [ID_W-1:0]   last_id, last_nxt;
    logic [BC_W-1:0]   burst_cnt, burst_nxt;
    logic [IC_W-1:0]   idle_cnt, idle_nxt;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   cand;
    logic [WIDTH-1:0]  data_arr [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_data
        assign data_arr[i] = src_data[i*WIDTH +: WIDTH];
    end

    assign busy = (state != IDLE);

    // Round-robin pick: descending scan so the source nearest last_id+1 wins.
    always_comb begin
        pick_id = last_id;
        cand    = '0;
        for (int i = int'(NUM_SRC); i >= 1; i--) begin
            cand = ID_W'((32'(last_id) + 32'(i)) % NUM_SRC);
            if (src_valid[cand]) begin
                pick_id = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            last_id   <= ID_W'(NUM_SRC - 1);
            burst_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_nxt;
            last_id   <= last_nxt;
            burst_cnt <= burst_nxt;
            idle_cnt  <= idle_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last_id;
        burst_nxt = burst_cnt;
        idle_nxt  = idle_cnt;
        tx_req    = 1'b0;
        tx_din    = '0;
        src_ready = '0;
        case (state)
            IDLE: begin
                if (|src_valid) begin
                    grant_nxt = pick_id;
                    burst_nxt = '0;
                    idle_nxt  = '0;
                    state_nxt = (ADD_HEADER != 0) ? HEADER : DATA;
                end
            end
            HEADER: begin
                tx_din = HDR_BASE | WIDTH'(grant_id);
                tx_req = tx_ready;
                if (tx_ready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx_din              = data_arr[grant_id];
                src_ready[grant_id] = tx_ready;
                tx_req              = tx_ready & src_valid[grant_id];
                if (tx_ready && src_valid[grant_id]) begin
                    burst_nxt = burst_cnt + BC_W'(1);
                    idle_nxt  = '0;
                    if (src_last[grant_id] || (32'(burst_cnt) + 32'd1 == MAX_BURST)) begin
                        state_nxt = IDLE;
                        last_nxt  = grant_id;
                    end
                end else if (src_valid[grant_id]) begin
                    // Backpressure from the UART is not source idleness.
                    idle_nxt = '0;
                end else if ((IDLE_TIMEOUT != 0) && (32'(idle_cnt) + 32'd1 >= IDLE_TIMEOUT)) begin
                    state_nxt = IDLE;
                    last_nxt  = grant_id;
                end else if (idle_cnt != IC_MAX) begin
                    idle_nxt = idle_cnt + IC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
